fdc_bus_bridge: RTL and testbench
=================================

Name: fdc_bus_bridge

Overview:
- Parametrised CPU-to-WD1793 front end for the CoCo/Dragon disk controller.
- Owns the $FF40 control register, the WD1793 clock-enable divider, and strobe synchronisation with address/data latching.
- Routes per-drive strobes, DRQ/INTRQ and read data for NUM_DRIVES controller instances.
- Adds a motor-off timeout, an access-overrun counter and per-drive mount tracking. The wd1793 instances sit downstream of this block.

Parameters:
NUM_DRIVES, 4, drive/controller count, legal range 1..8
CE_DIV, 7, wd_ce period in CLK cycles, legal range 2..63
SYNC_STAGES, 2, synchroniser depth for WD strobes, legal range 2..4
DS_THRESHOLD, 20'd368640, image size above which a drive is double-sided
MOTOR_TIMEOUT, 0, wd_ce ticks until motor auto-off; 0 disables the timeout

Ports:
CLK  in  1  system clock
RESET_N  in  1  asynchronous active-low reset
dragon  in  1  1 = Dragon register map, 0 = CoCo register map
ADDRESS  in  2  WD register address
DATA_IN  in  8  CPU write data
CTRL_WR_STB  in  1  one-CLK $FF40 write strobe
CTRL_RD  in  1  $FF40 read select
WD_RD_CTRL  in  1  asynchronous WD read level
WD_WR_CTRL  in  1  asynchronous WD write level
DATA_OUT  out  8  CPU read data
wd_ce  out  1  WD clock enable
wd_rd  out  NUM_DRIVES  per-drive read strobe
wd_wr  out  NUM_DRIVES  per-drive write strobe
wd_addr  out  2  latched address
wd_din  out  8  latched data
wd_dout  in  8*NUM_DRIVES  per-drive read data, drive i in bits [8i+7:8i]
wd_drq  in  NUM_DRIVES  per-drive DRQ
wd_intrq  in  NUM_DRIVES  per-drive INTRQ
img_mounted  in  NUM_DRIVES  per-drive mount pulse
img_readonly  in  1  mounted image is read-only
img_size  in  20  mounted image size in bytes
drive_wp  out  NUM_DRIVES  per-drive write protect
drive_ready  out  NUM_DRIVES  per-drive ready
drive_side  out  NUM_DRIVES  per-drive side select
HALT  out  1  CPU halt request
NMI_09  out  1  CPU NMI
FIRQ  out  1  CPU FIRQ
motor_on  out  1  motor state
overrun_cnt  out  8  dropped-access count, saturating

Behaviour:

Divider
- Counter runs 0..CE_DIV-1; wd_ce=1 only in the cycle where the count equals CE_DIV-1.
- Reset: count=0, wd_ce=0.

Control register (CTRL_WR_STB)
- CoCo map:
  - motor=D3, wprec=D4, density=D5, halt_en=D7, side=D6.
  - sel = index of lowest set bit of D[2:0].
  - If D[2:0]=0 and D6=1, sel=3.
  - If D[2:0]=0 and D6=0, sel holds its previous value and side=0.
- Dragon map: sel=D[1:0], motor=D2, density=D5, side=0.
- If sel>=NUM_DRIVES, no drive is selected: no strobes are issued, and drq/intrq/dout of the selected drive read as 0.
- Reset: all register fields 0 and sel=0.

HALT_EN
- Cleared in any cycle where the selected drive's intrq=1. This takes priority over a same-cycle write.
- Otherwise loaded from D7 on CTRL_WR_STB.

CPU-side outputs (combinational from selected drive)
- HALT = halt_en & ~drq.
- FIRQ = drq.
- NMI_09 = density & intrq.

DATA_OUT (priority order)
1. CTRL_RD: CoCo returns {halt_en, side, density, wprec, motor, D[2:0] as last written}; Dragon returns 8'h00.
2. Else WD_RD_CTRL high: wd_dout of the selected drive.
3. Else 8'h00.

Access FSM (states IDLE, PEND, HOLD)
- Both strobe levels pass through SYNC_STAGES flops. A rising edge is detected at the last stage.
- IDLE, on an edge:
  - Latch ADDRESS→wd_addr, DATA_IN→wd_din and sel→acc_sel; record the type; go to PEND.
  - Simultaneous read and write edges: the write wins and the read is discarded; no overrun is counted.
- PEND: strobe wd_rd[acc_sel] or wd_wr[acc_sel] is held high. On wd_ce=1 go to HOLD.
- HOLD: strobe still high for this one cycle; next state IDLE, strobe 0.
- An edge arriving in PEND or HOLD is dropped and overrun_cnt increments, saturating at 255.
- Control register writes during PEND do not change acc_sel.
- Worst-case strobe width is CE_DIV+1 cycles after the edge.

Motor timeout (MOTOR_TIMEOUT>0 only)
- A 24-bit counter reloads to MOTOR_TIMEOUT on a control write with motor=1, or on any access edge.
- It decrements on wd_ce while motor=1.
- When it reaches 0 while motor=1, motor clears.
- A control write in the same cycle as expiry wins.

Mount tracking (per drive)
- On a rising edge of img_mounted[i]:
  - drive_wp[i] <= img_readonly
  - drive_ready[i] <= (img_size != 0)
  - ds[i] <= (img_size > DS_THRESHOLD)
- These registers are not cleared by RESET_N; mounts persist across CPU reset. Power-up values are 0.
- drive_side[i] = ds[i] & side & (sel==i).

Reset during an access
- All strobes drop asynchronously, the FSM goes to IDLE, and the synchronisers clear.
- overrun_cnt resets to 0.

Test Plan:
1. CE_DIV=7: reset release → wd_ce pulses exactly every 7 CLK, first at cycle 6; no strobes active.
2. CoCo ctrl write 8'hA9, then WD_WR_CTRL high with ADDRESS=3, DATA_IN=8'h5A → sel=0, density=1, halt_en=1, side=0; wd_wr[0] high for one wd_ce plus 1 cycle; wd_addr=3, wd_din=8'h5A; other drives idle.
3. Ctrl write 8'h42, drive 1 mounted with img_size=737280 → drive_side[1]=1, drive_ready[1]=1; DATA_OUT on CTRL_RD = 8'h42.
4. halt_en=1 and selected DRQ toggles → HALT = ~drq; selected INTRQ asserts → halt_en clears next cycle, NMI_09 = density.
5. Second read edge inside PEND → dropped, overrun_cnt 0→1; 300 repetitions → overrun_cnt saturates at 255; simultaneous read and write edges in IDLE → only wd_wr asserted.
6. MOTOR_TIMEOUT=10, ctrl write 8'h09 with no access → motor_on falls after the 10th wd_ce; assert RESET_N=0 during PEND → strobes 0 immediately, drive_ready unchanged.

Source files
------------

// File: rtl/fdc_bus_bridge.sv
// rtl/fdc_bus_bridge.sv - CPU-to-WD1793 front end: control register, CE divider, strobe sync, drive routing
module fdc_bus_bridge #(
    parameter int          NUM_DRIVES    = 4,
    parameter int          CE_DIV        = 7,
    parameter int          SYNC_STAGES   = 2,
    parameter logic [19:0] DS_THRESHOLD  = 20'd368640,
    parameter int          MOTOR_TIMEOUT = 0
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic                      dragon,
    input  logic [1:0]                ADDRESS,
    input  logic [7:0]                DATA_IN,
    input  logic                      CTRL_WR_STB,
    input  logic                      CTRL_RD,
    input  logic                      WD_RD_CTRL,
    input  logic                      WD_WR_CTRL,
    output logic [7:0]                DATA_OUT,
    output logic                      wd_ce,
    output logic [NUM_DRIVES-1:0]     wd_rd,
    output logic [NUM_DRIVES-1:0]     wd_wr,
    output logic [1:0]                wd_addr,
    output logic [7:0]                wd_din,
    input  logic [8*NUM_DRIVES-1:0]   wd_dout,
    input  logic [NUM_DRIVES-1:0]     wd_drq,
    input  logic [NUM_DRIVES-1:0]     wd_intrq,
    input  logic [NUM_DRIVES-1:0]     img_mounted,
    input  logic                      img_readonly,
    input  logic [19:0]               img_size,
    output logic [NUM_DRIVES-1:0]     drive_wp,
    output logic [NUM_DRIVES-1:0]     drive_ready,
    output logic [NUM_DRIVES-1:0]     drive_side,
    output logic                      HALT,
    output logic                      NMI_09,
    output logic                      FIRQ,
    output logic                      motor_on,
    output logic [7:0]                overrun_cnt
);

    localparam logic [5:0]  CE_LAST  = 6'(CE_DIV - 1);
    localparam logic [23:0] MOT_LOAD = 24'(MOTOR_TIMEOUT);
    localparam bit          MOT_EN   = (MOTOR_TIMEOUT > 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_HOLD = 2'd2
    } acc_state_e;

    // Divider
    logic [5:0] ce_cnt_q, ce_cnt_d;

    // Control register fields
    logic [2:0] sel_q, sel_d;
    logic [2:0] dsel_q, dsel_d;
    logic       motor_q, motor_d;
    logic       wprec_q, wprec_d;
    logic       dens_q, dens_d;
    logic       side_q, side_d;
    logic       halt_q, halt_d;
    logic       wr_motor;

    // Motor timeout
    logic [23:0] mot_cnt_q, mot_cnt_d;
    logic        mot_expire;

    // Strobe synchronisers: top bit is the delayed copy of the last stage
    logic [SYNC_STAGES:0] rd_sync_q, wr_sync_q;
    logic                 rd_edge, wr_edge, any_edge;

    // Access FSM
    acc_state_e state_q, state_d;
    logic       acc_wr_q, acc_wr_d;
    logic [2:0] acc_sel_q, acc_sel_d;
    logic [1:0] addr_q, addr_d;
    logic [7:0] din_q, din_d;
    logic [7:0] ovr_q, ovr_d;

    // Selected-drive view
    logic       sel_drq, sel_intrq;
    logic [7:0] sel_dout;

    // Mount tracking survives CPU reset; only power-up clears it
    logic [NUM_DRIVES-1:0] mnt_prev_q = '0;
    logic [NUM_DRIVES-1:0] wp_q       = '0;
    logic [NUM_DRIVES-1:0] rdy_q      = '0;
    logic [NUM_DRIVES-1:0] ds_q       = '0;

    assign wd_ce    = (ce_cnt_q == CE_LAST);
    assign rd_edge  = rd_sync_q[SYNC_STAGES-1] & ~rd_sync_q[SYNC_STAGES];
    assign wr_edge  = wr_sync_q[SYNC_STAGES-1] & ~wr_sync_q[SYNC_STAGES];
    assign any_edge = rd_edge | wr_edge;

    // Divider next count: free-running 0..CE_DIV-1
    always_comb begin
        ce_cnt_d = (ce_cnt_q == CE_LAST) ? 6'd0 : ce_cnt_q + 6'd1;
    end

    // Mux DRQ/INTRQ/read data from the selected drive; out-of-range selects read as 0
    always_comb begin
        sel_drq   = 1'b0;
        sel_intrq = 1'b0;
        sel_dout  = 8'h00;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (sel_q == 3'(i)) begin
                sel_drq   = wd_drq[i];
                sel_intrq = wd_intrq[i];
                sel_dout  = wd_dout[8*i +: 8];
            end
        end
    end

    // Control register decode, halt enable and motor timeout next state
    always_comb begin
        sel_d     = sel_q;
        dsel_d    = dsel_q;
        motor_d   = motor_q;
        wprec_d   = wprec_q;
        dens_d    = dens_q;
        side_d    = side_q;
        halt_d    = halt_q;
        wr_motor  = dragon ? DATA_IN[2] : DATA_IN[3];
        mot_cnt_d = mot_cnt_q;
        mot_expire = MOT_EN && motor_q && (mot_cnt_q == 24'd0);

        if (CTRL_WR_STB) begin
            dsel_d  = DATA_IN[2:0];
            motor_d = wr_motor;
            wprec_d = DATA_IN[4];
            dens_d  = DATA_IN[5];
            if (dragon) begin
                sel_d  = {1'b0, DATA_IN[1:0]};
                side_d = 1'b0;
            end else begin
                side_d = DATA_IN[6];
                if (DATA_IN[0])      sel_d = 3'd0;
                else if (DATA_IN[1]) sel_d = 3'd1;
                else if (DATA_IN[2]) sel_d = 3'd2;
                else if (DATA_IN[6]) sel_d = 3'd3;
            end
        end else if (mot_expire) begin
            motor_d = 1'b0;
        end

        // A pending interrupt on the selected drive always kills halt
        if (sel_intrq)        halt_d = 1'b0;
        else if (CTRL_WR_STB) halt_d = DATA_IN[7];

        if ((CTRL_WR_STB && wr_motor) || any_edge) begin
            mot_cnt_d = MOT_LOAD;
        end else if (wd_ce && motor_q && (mot_cnt_q != 24'd0)) begin
            mot_cnt_d = mot_cnt_q - 24'd1;
        end
    end

    // Access FSM next state: one access in flight, extra edges counted as overruns
    always_comb begin
        state_d   = state_q;
        acc_wr_d  = acc_wr_q;
        acc_sel_d = acc_sel_q;
        addr_d    = addr_q;
        din_d     = din_q;
        ovr_d     = ovr_q;
        case (state_q)
            ST_IDLE: begin
                if (any_edge) begin
                    acc_wr_d  = wr_edge;
                    acc_sel_d = sel_q;
                    addr_d    = ADDRESS;
                    din_d     = DATA_IN;
                    state_d   = ST_PEND;
                end
            end
            ST_PEND: begin
                if (wd_ce) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if ((state_q != ST_IDLE) && any_edge && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end
    end

    // Per-drive strobes decoded from the FSM so reset drops them immediately
    always_comb begin
        wd_rd = '0;
        wd_wr = '0;
        if (state_q != ST_IDLE) begin
            for (int i = 0; i < NUM_DRIVES; i++) begin
                if (acc_sel_q == 3'(i)) begin
                    wd_wr[i] = acc_wr_q;
                    wd_rd[i] = ~acc_wr_q;
                end
            end
        end
    end

    // Side select reaches only the selected drive and only for double-sided images
    always_comb begin
        drive_side = '0;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            drive_side[i] = ds_q[i] & side_q & (sel_q == 3'(i));
        end
    end

    // CPU read data priority: control register, then WD data, else zero
    always_comb begin
        if (CTRL_RD) begin
            DATA_OUT = dragon ? 8'h00 : {halt_q, side_q, dens_q, wprec_q, motor_q, dsel_q};
        end else if (WD_RD_CTRL) begin
            DATA_OUT = sel_dout;
        end else begin
            DATA_OUT = 8'h00;
        end
    end

    // All CPU-reset state
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ce_cnt_q  <= 6'd0;
            sel_q     <= 3'd0;
            dsel_q    <= 3'd0;
            motor_q   <= 1'b0;
            wprec_q   <= 1'b0;
            dens_q    <= 1'b0;
            side_q    <= 1'b0;
            halt_q    <= 1'b0;
            mot_cnt_q <= 24'd0;
            rd_sync_q <= '0;
            wr_sync_q <= '0;
            state_q   <= ST_IDLE;
            acc_wr_q  <= 1'b0;
            acc_sel_q <= 3'd0;
            addr_q    <= 2'd0;
            din_q     <= 8'h00;
            ovr_q     <= 8'h00;
        end else begin
            ce_cnt_q  <= ce_cnt_d;
            sel_q     <= sel_d;
            dsel_q    <= dsel_d;
            motor_q   <= motor_d;
            wprec_q   <= wprec_d;
            dens_q    <= dens_d;
            side_q    <= side_d;
            halt_q    <= halt_d;
            mot_cnt_q <= mot_cnt_d;
            rd_sync_q <= {rd_sync_q[SYNC_STAGES-1:0], WD_RD_CTRL};
            wr_sync_q <= {wr_sync_q[SYNC_STAGES-1:0], WD_WR_CTRL};
            state_q   <= state_d;
            acc_wr_q  <= acc_wr_d;
            acc_sel_q <= acc_sel_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            ovr_q     <= ovr_d;
        end
    end

    // Capture image properties on each mount pulse rising edge
    always_ff @(posedge CLK) begin
        mnt_prev_q <= img_mounted;
        for (int i = 0; i < NUM_DRIVES; i++) begin
            if (img_mounted[i] && !mnt_prev_q[i]) begin
                wp_q[i]  <= img_readonly;
                rdy_q[i] <= (img_size != 20'd0);
                ds_q[i]  <= (img_size > DS_THRESHOLD);
            end
        end
    end

    assign wd_addr     = addr_q;
    assign wd_din      = din_q;
    assign drive_wp    = wp_q;
    assign drive_ready = rdy_q;
    assign HALT        = halt_q & ~sel_drq;
    assign FIRQ        = sel_drq;
    assign NMI_09      = dens_q & sel_intrq;
    assign motor_on    = motor_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_fdc_bus_bridge.sv
// tb/tb_fdc_bus_bridge.sv - directed self-checking bench for fdc_bus_bridge
module tb_fdc_bus_bridge;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        dragon;
    logic [1:0]  ADDRESS;
    logic [7:0]  DATA_IN;
    logic        CTRL_WR_STB;
    logic        CTRL_RD;
    logic        WD_RD_CTRL;
    logic        WD_WR_CTRL;
    logic [7:0]  DATA_OUT;
    logic        wd_ce;
    logic [3:0]  wd_rd;
    logic [3:0]  wd_wr;
    logic [1:0]  wd_addr;
    logic [7:0]  wd_din;
    logic [31:0] wd_dout;
    logic [3:0]  wd_drq;
    logic [3:0]  wd_intrq;
    logic [3:0]  img_mounted;
    logic        img_readonly;
    logic [19:0] img_size;
    logic [3:0]  drive_wp;
    logic [3:0]  drive_ready;
    logic [3:0]  drive_side;
    logic        HALT;
    logic        NMI_09;
    logic        FIRQ;
    logic        motor_on;
    logic [7:0]  overrun_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fdc_bus_bridge #(
        .NUM_DRIVES(4),
        .CE_DIV(7),
        .SYNC_STAGES(2),
        .DS_THRESHOLD(20'd368640),
        .MOTOR_TIMEOUT(10)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .dragon(dragon), .ADDRESS(ADDRESS),
        .DATA_IN(DATA_IN), .CTRL_WR_STB(CTRL_WR_STB), .CTRL_RD(CTRL_RD),
        .WD_RD_CTRL(WD_RD_CTRL), .WD_WR_CTRL(WD_WR_CTRL), .DATA_OUT(DATA_OUT),
        .wd_ce(wd_ce), .wd_rd(wd_rd), .wd_wr(wd_wr), .wd_addr(wd_addr),
        .wd_din(wd_din), .wd_dout(wd_dout), .wd_drq(wd_drq), .wd_intrq(wd_intrq),
        .img_mounted(img_mounted), .img_readonly(img_readonly), .img_size(img_size),
        .drive_wp(drive_wp), .drive_ready(drive_ready), .drive_side(drive_side),
        .HALT(HALT), .NMI_09(NMI_09), .FIRQ(FIRQ), .motor_on(motor_on),
        .overrun_cnt(overrun_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic ctrl_write(input logic [7:0] d);
        @(negedge CLK);
        DATA_IN     = d;
        CTRL_WR_STB = 1'b1;
        @(negedge CLK);
        CTRL_WR_STB = 1'b0;
        #1;
    endtask

    task automatic readback(input string tag, input logic [7:0] exp);
        CTRL_RD = 1'b1;
        #1;
        check(tag, DATA_OUT, exp);
        CTRL_RD = 1'b0;
        #1;
    endtask

    task automatic mount(input int idx, input logic [19:0] sz, input logic ro);
        @(negedge CLK);
        img_size         = sz;
        img_readonly     = ro;
        img_mounted[idx] = 1'b1;
        @(negedge CLK);
        img_mounted = '0;
        step(1);
    endtask

    // Returns on a sample (#1 after negedge) where wd_ce is high
    task automatic align_ce();
        bit ok = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (wd_ce) begin
                ok = 1;
                break;
            end
        end
        check("align_ce_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_strobe(input string tag);
        bit ok = 0;
        for (int i = 0; i < 50; i++) begin
            if ((wd_rd | wd_wr) != 4'b0000) begin
                ok = 1;
                break;
            end
            step(1);
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        int w, ce_n, ce_pos, nce;

        RESET_N      = 1'b0;
        dragon       = 1'b0;
        ADDRESS      = 2'd0;
        DATA_IN      = 8'h00;
        CTRL_WR_STB  = 1'b0;
        CTRL_RD      = 1'b0;
        WD_RD_CTRL   = 1'b0;
        WD_WR_CTRL   = 1'b0;
        wd_dout      = 32'hD3C2B1A0;
        wd_drq       = 4'b0000;
        wd_intrq     = 4'b0000;
        img_mounted  = 4'b0000;
        img_readonly = 1'b0;
        img_size     = 20'd0;

        // Reset state
        step(3);
        check("rst_wd_ce", 32'(wd_ce), 32'd0);
        check("rst_wd_rd", 32'(wd_rd), 32'd0);
        check("rst_wd_wr", 32'(wd_wr), 32'd0);
        check("rst_overrun", 32'(overrun_cnt), 32'd0);
        check("rst_motor", 32'(motor_on), 32'd0);
        check("rst_halt", 32'(HALT), 32'd0);
        check("rst_ready", 32'(drive_ready), 32'd0);
        readback("rst_ctrl_rd", 8'h00);

        // Divider: first wd_ce six cycles after release, then every 7
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        for (int k = 0; k < 21; k++) begin
            check("div_wd_ce", 32'(wd_ce), 32'((k % 7) == 6));
            if (k != 20) step(1);
        end
        check("div_no_strobe", 32'(wd_rd | wd_wr), 32'd0);

        // CoCo write 8'hA9 then a write access to register 3
        ctrl_write(8'hA9);
        readback("a9_ctrl_rd", 8'hA9);
        check("a9_motor", 32'(motor_on), 32'd1);
        check("a9_halt", 32'(HALT), 32'd1);
        align_ce();
        ADDRESS    = 2'd3;
        DATA_IN    = 8'h5A;
        WD_WR_CTRL = 1'b1;
        wait_strobe("wr_strobe_timeout");
        check("wr_strobe", 32'(wd_wr), 32'b0001);
        check("wr_no_rd", 32'(wd_rd), 32'd0);
        check("wr_addr", 32'(wd_addr), 32'd3);
        check("wr_din", 32'(wd_din), 32'h5A);
        w = 0; ce_n = 0; ce_pos = 0;
        while (wd_wr[0] && w < 20) begin
            w++;
            if (wd_ce) begin
                ce_n++;
                ce_pos = w;
            end
            step(1);
        end
        check("wr_width", 32'(w), 32'd6);
        check("wr_ce_count", 32'(ce_n), 32'd1);
        check("wr_hold_after_ce", 32'(ce_pos), 32'(w - 1));
        WD_WR_CTRL = 1'b0;
        step(4);

        // Control write during PEND must not retarget the access
        align_ce();
        WD_WR_CTRL = 1'b1;
        wait_strobe("pend_strobe_timeout");
        ctrl_write(8'h02);
        check("pend_acc_sel", 32'(wd_wr), 32'b0001);
        WD_WR_CTRL = 1'b0;
        step(10);
        check("pend_done", 32'(wd_wr), 32'd0);

        // Mounts, double-sided routing and threshold boundary
        ctrl_write(8'h42);
        mount(1, 20'd737280, 1'b0);
        mount(0, 20'd1000, 1'b0);
        mount(2, 20'd0, 1'b1);
        check("mnt_ready", 32'(drive_ready), 32'b0011);
        check("mnt_wp", 32'(drive_wp), 32'b0100);
        check("mnt_side", 32'(drive_side), 32'b0010);
        readback("x42_ctrl_rd", 8'h42);
        mount(3, 20'd368640, 1'b0);
        ctrl_write(8'h40);
        check("thr_eq_side", 32'(drive_side), 32'b0000);
        readback("x40_ctrl_rd", 8'h40);
        mount(3, 20'd368641, 1'b0);
        check("thr_gt_side", 32'(drive_side), 32'b1000);
        ctrl_write(8'h00);
        readback("x00_ctrl_rd", 8'h00);
        check("hold_side0", 32'(drive_side), 32'b0000);
        wd_drq = 4'b1000;
        #1;
        check("hold_sel3_firq", 32'(FIRQ), 32'd1);
        wd_drq = 4'b0000;

        // HALT/FIRQ/NMI and halt_en clear priority
        ctrl_write(8'hA1);
        check("halt_drq0", 32'(HALT), 32'd1);
        check("firq_drq0", 32'(FIRQ), 32'd0);
        wd_drq = 4'b0001;
        #1;
        check("halt_drq1", 32'(HALT), 32'd0);
        check("firq_drq1", 32'(FIRQ), 32'd1);
        wd_drq = 4'b0010;
        #1;
        check("halt_other_drq", 32'(HALT), 32'd1);
        wd_drq = 4'b0000;
        @(negedge CLK);
        wd_intrq = 4'b0001;
        #1;
        check("nmi_dens1", 32'(NMI_09), 32'd1);
        check("halt_before_clr", 32'(HALT), 32'd1);
        step(1);
        check("halt_cleared", 32'(HALT), 32'd0);
        wd_intrq = 4'b0000;
        @(negedge CLK);
        DATA_IN     = 8'hA1;
        CTRL_WR_STB = 1'b1;
        wd_intrq    = 4'b0001;
        @(negedge CLK);
        CTRL_WR_STB = 1'b0;
        wd_intrq    = 4'b0000;
        #1;
        check("intrq_beats_wr", 32'(HALT), 32'd0);
        readback("intrq_wr_ctrl_rd", 8'h21);
        ctrl_write(8'h81);
        wd_intrq = 4'b0001;
        #1;
        check("nmi_dens0", 32'(NMI_09), 32'd0);
        wd_intrq = 4'b0000;

        // Dragon map and DATA_OUT priority
        dragon = 1'b1;
        ctrl_write(8'h06);
        readback("drg_ctrl_rd", 8'h00);
        CTRL_RD    = 1'b1;
        WD_RD_CTRL = 1'b1;
        #1;
        check("drg_ctrl_rd_prio", 32'(DATA_OUT), 32'h00);
        CTRL_RD = 1'b0;
        #1;
        check("drg_wd_dout", 32'(DATA_OUT), 32'hC2);
        wait_strobe("drg_strobe_timeout");
        check("drg_rd_strobe", 32'(wd_rd), 32'b0100);
        WD_RD_CTRL = 1'b0;
        dragon     = 1'b0;
        readback("drg_fields", 8'h0E);
        step(12);

        // Overrun: second read edge inside PEND is dropped
        ctrl_write(8'h01);
        check("ovr_start", 32'(overrun_cnt), 32'd0);
        align_ce();
        WD_RD_CTRL = 1'b1;
        wait_strobe("ovr_strobe_timeout");
        check("ovr_rd_strobe", 32'(wd_rd), 32'b0001);
        @(negedge CLK);
        WD_RD_CTRL = 1'b0;
        @(negedge CLK);
        WD_RD_CTRL = 1'b1;
        step(3);
        check("ovr_one", 32'(overrun_cnt), 32'd1);
        step(1);
        check("ovr_no_new_access", 32'(wd_rd), 32'd0);
        WD_RD_CTRL = 1'b0;
        step(4);

        // Simultaneous edges in IDLE: write wins, no overrun
        @(negedge CLK);
        WD_RD_CTRL = 1'b1;
        WD_WR_CTRL = 1'b1;
        #1;
        wait_strobe("sim_strobe_timeout");
        check("sim_wr", 32'(wd_wr), 32'b0001);
        check("sim_rd", 32'(wd_rd), 32'd0);
        WD_RD_CTRL = 1'b0;
        WD_WR_CTRL = 1'b0;
        step(12);
        check("sim_ovr", 32'(overrun_cnt), 32'd1);

        // Saturation at 255
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            WD_RD_CTRL = ~WD_RD_CTRL;
        end
        WD_RD_CTRL = 1'b0;
        step(12);
        check("ovr_saturate", 32'(overrun_cnt), 32'd255);

        // Motor timeout: falls after the 10th wd_ce
        ctrl_write(8'h09);
        nce = 0;
        for (int i = 0; i < 300; i++) begin
            if (!motor_on) break;
            if (wd_ce) nce++;
            step(1);
        end
        check("motor_ce_count", 32'(nce), 32'd10);
        check("motor_off", 32'(motor_on), 32'd0);

        // Reset during PEND
        WD_WR_CTRL = 1'b1;
        wait_strobe("rstp_strobe_timeout");
        check("rstp_strobe", 32'(wd_wr), 32'b0001);
        #2;
        RESET_N = 1'b0;
        #1;
        check("rstp_wr", 32'(wd_wr), 32'd0);
        check("rstp_rd", 32'(wd_rd), 32'd0);
        check("rstp_ovr", 32'(overrun_cnt), 32'd0);
        check("rstp_ready", 32'(drive_ready), 32'b1011);
        check("rstp_wp", 32'(drive_wp), 32'b0100);
        step(3);
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        check("rstp_ready_after", 32'(drive_ready), 32'b1011);
        wait_strobe("rstp_resync_timeout");
        check("rstp_resync_wr", 32'(wd_wr), 32'b0001);
        WD_WR_CTRL = 1'b0;
        step(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
